down_timer: RTL
===============

# down_timer

Loadable down-counting timer: the count-down partner of the project's 4-bit loadable up counter. It is preloaded with a value, decrements once per prescaled tick after `start`, and flags terminal count when the value reaches zero. It sits beside the up counter in the timing datapath and drives the "time expired" events for the control FSM. It supports pause/resume and restart from the last loaded value.

## Interface
- `WIDTH`, 4: counter width in bits.
- `PRESCALE`, 1: number of RUN clocks per decrement; must be ≥1.

Ports:
- `clk` in 1: clock, rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ld` in 1: load `D` into `Q` and into the reload register; aborts any run.
- `D` in WIDTH: load value.
- `start` in 1: begin or restart counting.
- `pause` in 1: level-sensitive; holds the count while high.
- `Q` out WIDTH: current count.
- `tc` out 1: registered one-cycle terminal-count pulse.
- `busy` out 1: high in RUN or PAUSE.
- `done` out 1: high in DONE.

## Operation
- Reset values: `Q`=0, reload=0, state IDLE, prescaler=0, `tc`=0, `busy`=0, `done`=0.
- States and transitions:
  - IDLE:
    - `start` and `Q`≠0 → RUN.
    - `start` and `Q`=0 → DONE, and `tc` pulses.
  - RUN:
    - On each tick, `Q`←`Q`−1.
    - Tick with `Q`=1 → `Q`←0, `tc`←1, → DONE.
    - `pause` → PAUSE.
  - PAUSE:
    - `Q` and the prescaler are frozen.
    - `pause` low → RUN; the prescaler resumes from its held value.
  - DONE:
    - `start` → `Q`←reload, prescaler←0.
    - Then → RUN if reload≠0, otherwise stay in DONE and pulse `tc`.
- Priority within one cycle: `ld` > `start` > `pause` > tick.
- `ld` in any state:
  - `Q`←`D`, reload←`D`, prescaler←0, → IDLE.
  - `tc` is never asserted by `ld`, even when `D`=0.
- `start` in RUN or PAUSE: restart with `Q`←reload, prescaler←0, → RUN.
- Tick definition: `tick` = RUN ∧ ¬`pause` ∧ (prescaler = `PRESCALE`−1).
  - The prescaler counts 0..`PRESCALE`−1 in RUN only and wraps to 0 on tick.
- Arithmetic: unsigned, WIDTH bits. `Q` never decrements below 0; there is no underflow wrap.

## Timing
- `start` sampled at edge k → RUN after edge k.
- First decrement at edge k+`PRESCALE`; subsequent decrements every `PRESCALE` edges.
- `tc` is registered and high for exactly the one cycle following the edge at which `Q` becomes 0 (or reloads, with auto-reload).
- `done` rises on that same edge. It stays high until `ld` or `start`.
- `pause` asserted before edge j → no decrement at edge j.
- The frozen prescaler phase is preserved across a pause.
- Reset mid-operation: all outputs return to reset values immediately (async). No `tc` is emitted.

## Configuration
- `DOWN_TIMER_AUTORELOAD_EN` defined:
  - The terminal tick with `Q`=1 loads `Q`←reload and pulses `tc`.
  - The state stays RUN, so the timer runs periodically with period reload×`PRESCALE` clocks.
  - `done` is never asserted from RUN.
- Undefined: one-shot behaviour as described in Operation.

## Structure
- Shared package `timer_pkg`:
  - State enum `timer_state_t` (IDLE, RUN, PAUSE, DONE).
  - Default width constant `TIMER_W`=4.
- Sub-module `tick_prescaler` (parameter `PRESCALE`):
  - Inputs: enable and clear.
  - Output: `tick`.
  - Contains a counter of width $clog2(`PRESCALE`)+1.
- Top level: FSM, `Q` register, reload register, `tc` register.

## Test plan
- `PRESCALE`=1, `ld` `D`=3, `start` → `Q` = 3,2,1,0 on successive cycles; `tc` high one cycle with `Q`=0; `done`=1, `busy`=0.
- `PRESCALE`=3, `D`=2, `start` → `Q`=1 after 3 clocks and `Q`=0 after 6 clocks; exactly one `tc` pulse.
- `D`=5, run to `Q`=3, `pause` held 5 cycles → `Q` holds 3 and `busy`=1; after release the next decrement arrives with the preserved prescaler phase.
- `ld` `D`=7 while RUN at `Q`=2 → IDLE, `Q`=7, no `tc`; in DONE, `start` → `Q`=7 and countdown restarts.
- Assert `rst_n` low mid-RUN → `Q`=0, IDLE, `tc`=`busy`=`done`=0 asynchronously.
- With `DOWN_TIMER_AUTORELOAD_EN`, `D`=3, `PRESCALE`=1 → `Q` = 3,2,1,3,2,1…; `tc` pulses every 3 cycles; `done` stays 0.

Source files
------------

// File: rtl/down_timer_pkg.sv
// timer_pkg: shared state encoding and default width for the timing datapath counters.
package timer_pkg;
    localparam int TIMER_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;
endpackage

// File: rtl/down_timer_if.sv
// down_timer_if: control/status bundle between the control FSM (master) and down_timer (slave).
interface down_timer_if #(parameter int WIDTH = 4);
    logic             ld;
    logic [WIDTH-1:0] D;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] Q;
    logic             tc;
    logic             busy;
    logic             done;
    modport master (output ld, D, start, pause, input Q, tc, busy, done);
    modport slave  (input ld, D, start, pause, output Q, tc, busy, done);
endinterface

// File: rtl/down_timer_tick_prescaler.sv
// tick_prescaler: divides enabled clocks by PRESCALE; phase holds while enable is low.
module tick_prescaler #(parameter int PRESCALE = 1) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(PRESCALE) + 1;
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(PRESCALE - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with pause/restart and terminal-count pulse.
// Define DOWN_TIMER_AUTORELOAD_EN for periodic reload instead of one-shot stop in DONE.
module down_timer import timer_pkg::*; #(
    parameter int WIDTH    = TIMER_W,
    parameter int PRESCALE = 1
) (
    input logic        clk,
    input logic        rst_n,
    down_timer_if.slave bus
);
    timer_state_t     state;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] reload;
    logic             tc;
    logic             tick;
    tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state == RUN && !bus.pause),
        .clr  (bus.ld || bus.start),
        .tick (tick)
    );
    // q always equals reload while IDLE, so start from any state restarts from reload
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            q      <= '0;
            reload <= '0;
            tc     <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (bus.ld) begin
                q      <= bus.D;
                reload <= bus.D;
                state  <= IDLE;
            end else if (bus.start) begin
                q     <= reload;
                state <= reload != '0 ? RUN : DONE;
                tc    <= reload == '0;
            end else if (state == RUN && bus.pause) state <= PAUSE;
            else if (state == PAUSE && !bus.pause) state <= RUN;
            else if (tick) begin
                if (q == WIDTH'(1)) begin
`ifdef DOWN_TIMER_AUTORELOAD_EN
                    q <= reload;
`else
                    q     <= '0;
                    state <= DONE;
`endif
                    tc <= 1'b1;
                end else q <= q - WIDTH'(1);
            end
        end
    assign bus.Q    = q;
    assign bus.tc   = tc;
    assign bus.busy = state == RUN || state == PAUSE;
    assign bus.done = state == DONE;
endmodule
